// File: rtl/l2_write_combiner.sv
// Write combiner in front of L2: merges byte-enabled 16-bit word writes into a
// single 256-bit line buffer and offers the finished or flushed line to L2.
module l2_write_combiner (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [15:0]  wr_addr,
   input  logic [15:0]  wr_data,
   input  logic [1:0]   wr_byte_enable,
   input  logic         flush,
   output logic         line_valid,
   input  logic         line_ready,
   output logic [15:0]  line_addr,
   output logic [255:0] line_data,
   output logic [31:0]  line_mask,
   output logic         empty
);

   typedef enum logic [1:0] {EMPTY, FILLING, DRAIN} state_t;

   state_t       state;
   logic [10:0]  tag;
   logic [255:0] buf_data;
   logic [31:0]  buf_mask;
   logic [255:0] merged_data;
   logic [31:0]  merged_mask;
   logic         tag_match;
   logic         accept;
   logic [7:0]   bit_base;
   logic [4:0]   byte_base;
   logic         unused_addr_lsb;

   assign unused_addr_lsb = wr_addr[0];
   assign tag_match       = (wr_addr[15:5] == tag);
   assign accept          = wr_valid && wr_ready;
   assign bit_base        = {wr_addr[4:1], 4'b0000};
   assign byte_base       = {wr_addr[4:1], 1'b0};

   always_comb begin
      wr_ready = 1'b0;
      case (state)
         EMPTY:   wr_ready = 1'b1;
         FILLING: wr_ready = tag_match;
         default: wr_ready = 1'b0;
      endcase
   end

   // Buffer contents as they would look after this cycle's write, if any
   always_comb begin
      merged_data = buf_data;
      merged_mask = buf_mask;
      if (accept && wr_byte_enable[0]) begin
         merged_data[bit_base +: 8] = wr_data[7:0];
         merged_mask[byte_base]     = 1'b1;
      end
      if (accept && wr_byte_enable[1]) begin
         merged_data[bit_base + 8'd8 +: 8] = wr_data[15:8];
         merged_mask[byte_base + 5'd1]     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         tag      <= '0;
         buf_data <= '0;
         buf_mask <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept && (wr_byte_enable != 2'b00)) begin
                  tag      <= wr_addr[15:5];
                  buf_data <= merged_data;
                  buf_mask <= merged_mask;
                  state    <= FILLING;
               end
            end
            FILLING: begin
               buf_data <= merged_data;
               buf_mask <= merged_mask;
               // A mismatching write evicts the line; it is retried once EMPTY
               if ((&merged_mask) || flush || (wr_valid && !tag_match))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (line_ready) begin
                  buf_data <= '0;
                  buf_mask <= '0;
                  state    <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign line_valid = (state == DRAIN);
   assign empty      = (state == EMPTY);
   assign line_addr  = {tag, 5'b00000};
   assign line_data  = buf_data;
   assign line_mask  = buf_mask;

endmodule

// File: tb/tb_l2_write_combiner.sv
// Scoreboard bench for l2_write_combiner: directed writes push expected lines,
// a monitor pops and compares them on every line handshake.
module tb_l2_write_combiner;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         wr_valid;
   logic         wr_ready;
   logic [15:0]  wr_addr;
   logic [15:0]  wr_data;
   logic [1:0]   wr_byte_enable;
   logic         flush;
   logic         line_valid;
   logic         line_ready;
   logic [15:0]  line_addr;
   logic [255:0] line_data;
   logic [31:0]  line_mask;
   logic         empty;

   typedef struct {
      logic [15:0]  addr;
      logic [255:0] data;
      logic [31:0]  mask;
   } line_t;

   line_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   l2_write_combiner dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_byte_enable (wr_byte_enable),
      .flush          (flush),
      .line_valid     (line_valid),
      .line_ready     (line_ready),
      .line_addr      (line_addr),
      .line_data      (line_data),
      .line_mask      (line_mask),
      .empty          (empty)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] d,
                                input logic [1:0] be, input logic f, input logic lr);
      wr_valid       = v;
      wr_addr        = a;
      wr_data        = d;
      wr_byte_enable = be;
      flush          = f;
      line_ready     = lr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [15:0] a, input logic [255:0] d, input logic [31:0] m);
      line_t l;
      l.addr = a;
      l.data = d;
      l.mask = m;
      exp_q.push_back(l);
   endtask

   // Every handshake sampled mid-cycle must match the oldest expected line
   always @(negedge clk) begin
      if (reset_n && line_valid && line_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_line", 256'(line_addr), 256'hFFFFFFFF);
         end else begin
            line_t e;
            e = exp_q.pop_front();
            checkOutput("line_addr", 256'(line_addr), 256'(e.addr));
            checkOutput("line_data", line_data, e.data);
            checkOutput("line_mask", 256'(line_mask), 256'(e.mask));
         end
      end
   end

   initial begin
      logic [255:0] d;

      reset_n = 1'b0;
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      #3;
      checkOutput("rst_empty", 256'(empty), 256'(1'b1));
      checkOutput("rst_wr_ready", 256'(wr_ready), 256'(1'b1));
      checkOutput("rst_line_valid", 256'(line_valid), 256'(1'b0));
      checkOutput("rst_line_mask", 256'(line_mask), 256'h0);
      checkOutput("rst_line_data", line_data, 256'h0);
      checkOutput("rst_line_addr", 256'(line_addr), 256'h0);
      #9 reset_n = 1'b1;
      tick();

      // Single word then flush
      applyStimulus(1'b1, 16'h1234, 16'hBEEF, 2'b11, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t1_wr_ready", 256'(wr_ready), 256'(1'b1));
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("t1_no_valid_filling", 256'(line_valid), 256'(1'b0));
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      d = '0;
      d[175:160] = 16'hBEEF;
      push_line(16'h1220, d, 32'h00300000);
      @(negedge clk);
      checkOutput("t1_valid_after_flush", 256'(line_valid), 256'(1'b1));
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1_back_empty", 256'(empty), 256'(1'b1));
      checkOutput("t1_mask_cleared", 256'(line_mask), 256'h0);
      tick();

      // Zero byte enable and flush while EMPTY change nothing
      applyStimulus(1'b1, 16'h0100, 16'hFFFF, 2'b00, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t2_still_empty", 256'(empty), 256'(1'b1));
      checkOutput("t2_mask_zero", 256'(line_mask), 256'h0);
      checkOutput("t2_no_valid", 256'(line_valid), 256'(1'b0));
      tick();

      // Full line by sixteen writes, no flush
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 16'h4000 + 16'(2 * i), 16'(i), 2'b11, 1'b0, 1'b0);
         if (i == 15) begin
            @(negedge clk);
            checkOutput("t3_not_early", 256'(line_valid), 256'(1'b0));
         end
         tick();
      end
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      d = '0;
      for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'(i);
      push_line(16'h4000, d, 32'hFFFFFFFF);
      @(negedge clk);
      checkOutput("t3_valid_next_cycle", 256'(line_valid), 256'(1'b1));
      checkOutput("t3_full_mask", 256'(line_mask), 256'hFFFFFFFF);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      tick();

      // Two byte-lane writes to the same word
      applyStimulus(1'b1, 16'h0002, 16'h00AA, 2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0002, 16'hBB00, 2'b10, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t4_word1", 256'(line_data[31:16]), 256'h0000BBAA);
      checkOutput("t4_mask", 256'(line_mask), 256'h0000000C);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      d = '0;
      d[31:16] = 16'hBBAA;
      push_line(16'h0000, d, 32'h0000000C);
      tick();

      // Tag mismatch evicts; line held while L2 stalls; stalled write retried
      applyStimulus(1'b1, 16'h0000, 16'h1111, 2'b11, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0040, 16'h2222, 2'b11, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t5_stall", 256'(wr_ready), 256'(1'b0));
      tick();
      d = '0;
      d[15:0] = 16'h1111;
      push_line(16'h0000, d, 32'h00000003);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 16'h0040, 16'h2222, 2'b11, (k == 1), 1'b0);
         @(negedge clk);
         checkOutput("t5_hold_valid", 256'(line_valid), 256'(1'b1));
         checkOutput("t5_hold_addr", 256'(line_addr), 256'h0);
         checkOutput("t5_hold_data", line_data, d);
         checkOutput("t5_hold_mask", 256'(line_mask), 256'h3);
         checkOutput("t5_drain_no_ready", 256'(wr_ready), 256'(1'b0));
         tick();
      end
      applyStimulus(1'b1, 16'h0040, 16'h2222, 2'b11, 1'b0, 1'b1);
      tick();
      @(negedge clk);
      checkOutput("t5_retry_ready", 256'(wr_ready), 256'(1'b1));
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b1);
      tick();
      d = '0;
      d[15:0] = 16'h2222;
      push_line(16'h0040, d, 32'h00000003);
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      tick();

      // Write and flush in the same cycle
      applyStimulus(1'b1, 16'h0800, 16'h1357, 2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0806, 16'h5A5A, 2'b11, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t6_wr_ready", 256'(wr_ready), 256'(1'b1));
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      d = '0;
      d[15:0]  = 16'h0057;
      d[63:48] = 16'h5A5A;
      push_line(16'h0800, d, 32'h000000C1);
      @(negedge clk);
      checkOutput("t6_valid", 256'(line_valid), 256'(1'b1));
      tick();

      // Asynchronous reset in the middle of DRAIN
      applyStimulus(1'b1, 16'h2000, 16'h00FF, 2'b11, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t7_in_drain", 256'(line_valid), 256'(1'b1));
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t7_async_valid", 256'(line_valid), 256'(1'b0));
      checkOutput("t7_async_mask", 256'(line_mask), 256'h0);
      checkOutput("t7_async_data", line_data, 256'h0);
      checkOutput("t7_async_empty", 256'(empty), 256'(1'b1));
      checkOutput("t7_async_wr_ready", 256'(wr_ready), 256'(1'b1));
      #1 reset_n = 1'b1;
      applyStimulus(1'b1, 16'h3000, 16'hCAFE, 2'b10, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t7_first_write_mask", 256'(line_mask), 256'h2);
      checkOutput("t7_first_write_filling", 256'(empty), 256'(1'b0));
      tick();
      d = '0;
      d[15:0] = 16'hCA00;
      push_line(16'h3000, d, 32'h00000002);
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
      tick();

      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("sb_all_lines_seen", 256'(exp_q.size()), 256'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_write_combiner.md
L2_WRITE_COMBINER -- requirements
Module: l2_write_combiner

Interface
REQ-001 Parameters SHALL be: none; line geometry is fixed at 256-bit line (lc3b_burst), 16 words, 32 bytes.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 wr_valid  input  1  word-write request present.
REQ-005 wr_ready  output  1  write accepted this cycle when high together with wr_valid.
REQ-006 wr_addr  input  16  byte address; tag = wr_addr[15:5], word index = wr_addr[4:1], wr_addr[0] ignored.
REQ-007 wr_data  input  16  write word; bits [7:0] low byte, [15:8] high byte.
REQ-008 wr_byte_enable  input  2  bit0 enables low byte, bit1 enables high byte.
REQ-009 flush  input  1  one-cycle request to drain the buffered line.
REQ-010 line_valid  output  1  merged line offered to L2.
REQ-011 line_ready  input  1  L2 accepts offered line when high with line_valid.
REQ-012 line_addr  output  16  {buffered tag, 5'b0}.
REQ-013 line_data  output  256  merged line; word i at bits [16i+15:16i].
REQ-014 line_mask  output  32  per-byte written mask; bit b covers line_data[8b+7:8b].
REQ-015 empty  output  1  high when state is EMPTY.

Function
REQ-016 State machine SHALL have exactly three states: EMPTY, FILLING, DRAIN.
REQ-017 wr_ready SHALL be combinational: 1 in EMPTY; 1 in FILLING iff wr_addr tag equals buffered tag; 0 in DRAIN.
REQ-018 Accepted write SHALL merge only enabled bytes of word index i into bytes 2i/2i+1 of the line buffer and set the matching mask bits; later writes overwrite earlier bytes.
REQ-019 EMPTY, accepted write with nonzero byte enable: load tag, merge, go FILLING next cycle.
REQ-020 EMPTY, accepted write with byte enable 2'b00: no state, tag, data or mask change.
REQ-021 EMPTY, flush: ignored, stay EMPTY.
REQ-022 FILLING, accepted write: merge; if resulting mask is all-ones go DRAIN, else stay FILLING.
REQ-023 FILLING, wr_valid with tag mismatch: write stalled (wr_ready 0), go DRAIN next cycle (eviction); stalled write accepted after return to EMPTY.
REQ-024 FILLING, flush: go DRAIN; if a write is accepted the same cycle it SHALL be merged before DRAIN.
REQ-025 DRAIN: line_valid 1; line_addr, line_data, line_mask SHALL hold stable until handshake.
REQ-026 DRAIN with line_ready 1: clear data and mask to 0, go EMPTY next cycle; earliest new write acceptance is the following cycle.
REQ-027 line_valid SHALL be 0 outside DRAIN; line_data/line_mask reflect buffer contents in all states.
REQ-028 flush in DRAIN SHALL be ignored.
REQ-029 Latency: full-line write merged in cycle N SHALL give line_valid in cycle N+1.

Reset
REQ-030 On reset_n low, immediately and independent of clk: state EMPTY, tag 0, line_data 0, line_mask 0, line_valid 0, empty 1, wr_ready 1.
REQ-031 Reset asserted in DRAIN SHALL drop line_valid asynchronously and discard the line; no partial handshake recorded.
REQ-032 After reset_n release, first rising edge SHALL accept writes normally.

Verification
REQ-033 Write 0xBEEF, be=11, addr 0x1234 (word 10), then flush, line_ready=1 -> line_valid 1 cycle after flush, line_addr 0x1220, line_data[175:160]=0xBEEF, line_mask=0x00300000, then EMPTY.
REQ-034 16 writes to addr 0x4000..0x401E, be=11, data=index -> line_valid next cycle after 16th, line_mask=0xFFFFFFFF, word i = i, no flush needed.
REQ-035 Write 0x00AA be=01 then 0xBB00 be=10 to same word 0x0002 -> word 1 = 0xBBAA, mask bits 2,3 set.
REQ-036 Buffer holding tag 0x000, write to 0x0040 -> wr_ready 0, DRAIN next cycle, line_ready held 0 for 3 cycles keeps outputs stable, after handshake write accepted into fresh line with line_addr 0x0040.
REQ-037 Write plus flush same cycle -> drained line contains that write.
REQ-038 Assert reset_n low mid-DRAIN between clock edges -> line_valid 0 and line_mask 0 before next edge.
